// File: rtl/string_sender.sv
// Bit-serial message sender with valid/ready handshake and a configurable idle gap after each bit.
// Sized by `STR_LEN / `LOG_STR_LEN (normally from macros.v); define STRING_SENDER_PARITY_EN to append an even-parity bit.

`ifndef STR_LEN
`define STR_LEN 8
`endif
`ifndef LOG_STR_LEN
`define LOG_STR_LEN 3
`endif

module string_sender #(
  parameter int IDLE_GAP = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [`STR_LEN-1:0]     in_string,
  input  logic [`LOG_STR_LEN-1:0] eos,
  input  logic                    tx_ready,
  output logic                    tx_valid,
  output logic                    tx_bit,
  output logic [`LOG_STR_LEN:0]   tx_index,
  output logic                    busy,
  output logic                    send_done
);

  localparam int STR_LEN = `STR_LEN;
  localparam int LW      = `LOG_STR_LEN;
  // Counter width of clog2(IDLE_GAP+1), kept at least one bit so IDLE_GAP=0 still elaborates.
  localparam int GW      = (IDLE_GAP > 0) ? $clog2(IDLE_GAP + 1) : 1;

  localparam logic [LW:0]   LAST_IDX = (LW + 1)'(STR_LEN - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((IDLE_GAP > 0) ? IDLE_GAP - 1 : 0);
`ifdef STRING_SENDER_PARITY_EN
  localparam logic [LW:0]   PAR_IDX  = (LW + 1)'(STR_LEN);
`endif

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    GAP,
`ifdef STRING_SENDER_PARITY_EN
    PARITY,
`endif
    DONE
  } state_t;

  state_t             state, state_d;
  logic [LW:0]        index, index_d;
  logic [GW-1:0]      gap_cnt, gap_d;
  logic [STR_LEN-1:0] shadow, shadow_d;
  logic               cur_bit;
`ifdef STRING_SENDER_PARITY_EN
  logic               parity, parity_d;
`endif

  assign cur_bit = shadow[index[LW-1:0]];

  // Next-state and datapath update.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path can infer a latch.
    state_d  = state;
    index_d  = index;
    gap_d    = gap_cnt;
    shadow_d = shadow;
`ifdef STRING_SENDER_PARITY_EN
    parity_d = parity;
`endif
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          shadow_d = in_string;
          index_d  = {1'b0, eos};
`ifdef STRING_SENDER_PARITY_EN
          parity_d = 1'b0;
`endif
          state_d  = SEND;
        end
      end
      SEND: begin
        if (tx_ready) begin
          gap_d = '0;
`ifdef STRING_SENDER_PARITY_EN
          parity_d = parity ^ cur_bit;
`endif
          if (index == LAST_IDX) begin
`ifdef STRING_SENDER_PARITY_EN
            // Parking the index on STR_LEN tells GAP that the parity bit comes next.
            index_d = PAR_IDX;
            state_d = (IDLE_GAP > 0) ? GAP : PARITY;
`else
            state_d = DONE;
`endif
          end else begin
            index_d = index + (LW + 1)'(1);
            state_d = (IDLE_GAP > 0) ? GAP : SEND;
          end
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          gap_d = '0;
`ifdef STRING_SENDER_PARITY_EN
          state_d = (index == PAR_IDX) ? PARITY : SEND;
`else
          state_d = SEND;
`endif
        end else begin
          gap_d = gap_cnt + GW'(1);
        end
      end
`ifdef STRING_SENDER_PARITY_EN
      PARITY: begin
        if (tx_ready) state_d = DONE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      index   <= '0;
      gap_cnt <= '0;
      // NOTE: the shadow register is reset like any flop; it is a plain register, not a RAM.
      shadow  <= '0;
`ifdef STRING_SENDER_PARITY_EN
      parity  <= 1'b0;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      state   <= state_d;
      index   <= index_d;
      gap_cnt <= gap_d;
      shadow  <= shadow_d;
`ifdef STRING_SENDER_PARITY_EN
      parity  <= parity_d;
`endif
    end
  end

  // Moore outputs; bit and index read as zero whenever nothing is offered.
  always_comb begin
    tx_valid  = 1'b0;
    tx_bit    = 1'b0;
    tx_index  = '0;
    busy      = (state != IDLE) && (state != DONE);
    send_done = (state == DONE);
    case (state)
      SEND: begin
        tx_valid = 1'b1;
        tx_bit   = cur_bit;
        tx_index = index;
      end
`ifdef STRING_SENDER_PARITY_EN
      PARITY: begin
        tx_valid = 1'b1;
        tx_bit   = parity;
        tx_index = PAR_IDX;
      end
`endif
      default: ;
    endcase
  end

  property p_hold_while_stalled;
    @(posedge clk) disable iff (rst)
      tx_valid && !tx_ready |=> tx_valid && $stable(tx_bit) && $stable(tx_index);
  endproperty
  a_hold_while_stalled: assert property (p_hold_while_stalled);

endmodule

// File: tb/tb_string_sender.sv
// Directed table-driven bench for string_sender (STR_LEN=8, IDLE_GAP=2); follows STRING_SENDER_PARITY_EN if defined.

`ifndef STR_LEN
`define STR_LEN 8
`endif
`ifndef LOG_STR_LEN
`define LOG_STR_LEN 3
`endif

module tb_string_sender;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    start;
  logic [`STR_LEN-1:0]     in_string;
  logic [`LOG_STR_LEN-1:0] eos;
  logic                    tx_ready;
  logic                    tx_valid;
  logic                    tx_bit;
  logic [`LOG_STR_LEN:0]   tx_index;
  logic                    busy;
  logic                    send_done;

  always #5 clk = ~clk;

  string_sender #(.IDLE_GAP(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_string (in_string),
    .eos       (eos),
    .tx_ready  (tx_ready),
    .tx_valid  (tx_valid),
    .tx_bit    (tx_bit),
    .tx_index  (tx_index),
    .busy      (busy),
    .send_done (send_done)
  );

  // One row per clock edge: inputs sampled at that edge, outputs expected just before it.
  typedef struct {
    logic       rst;
    logic       start;
    logic [7:0] data;
    logic [2:0] eos;
    logic       ready;
    logic       ev;
    logic       eb;
    logic [3:0] ei;
    logic       ebusy;
    logic       edone;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic s, input logic [7:0] d, input logic [2:0] e,
                              input logic rdy, input logic ev, input logic eb, input logic [3:0] ei,
                              input logic ebusy, input logic edone);
    vec_t v;
    v.rst = r; v.start = s; v.data = d; v.eos = e; v.ready = rdy;
    v.ev = ev; v.eb = eb; v.ei = ei; v.ebusy = ebusy; v.edone = edone;
    return v;
  endfunction

  task automatic apply(input vec_t v, input string tag);
    rst       = v.rst;
    start     = v.start;
    in_string = v.data;
    eos       = v.eos;
    tx_ready  = v.ready;
    #1;
    n_vec++;
    check({tag, " tx_valid"},  32'(tx_valid),  32'(v.ev));
    check({tag, " busy"},      32'(busy),      32'(v.ebusy));
    check({tag, " send_done"}, 32'(send_done), 32'(v.edone));
    if (v.ev) begin
      check({tag, " tx_bit"},   32'(tx_bit),   32'(v.eb));
      check({tag, " tx_index"}, 32'(tx_index), 32'(v.ei));
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Expected timeline of one full transmission with tx_ready held high:
  // a bit every third cycle starting one cycle after start, two gap cycles between bits.
  task automatic add_run(input logic [7:0] data, input logic [2:0] e,
                         input logic [7:0] exp_bits, input logic prev_done);
    int   n;
    int   last;
    int   k;
    logic par;
    n    = 8 - int'(e);
    last = 1 + 3 * (n - 1);
    par  = 1'b0;
    vecs.push_back(mk(0, 1, data, e, 1, 0, 0, 4'd0, 0, prev_done));
    for (int c = 1; c <= last; c++) begin
      if ((c - 1) % 3 == 0) begin
        k   = int'(e) + (c - 1) / 3;
        par = par ^ exp_bits[k];
        vecs.push_back(mk(0, 0, data, e, 1, 1, exp_bits[k], 4'(k), 1, 0));
      end else begin
        vecs.push_back(mk(0, 0, data, e, 1, 0, 0, 4'd0, 1, 0));
      end
    end
`ifdef STRING_SENDER_PARITY_EN
    vecs.push_back(mk(0, 0, data, e, 1, 0, 0, 4'd0, 1, 0));
    vecs.push_back(mk(0, 0, data, e, 1, 0, 0, 4'd0, 1, 0));
    vecs.push_back(mk(0, 0, data, e, 1, 1, par, 4'd8, 1, 0));
`endif
    vecs.push_back(mk(0, 0, data, e, 1, 0, 0, 4'd0, 0, 1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int   base;
    vec_t tmp;

    rst = 1'b1; start = 1'b0; in_string = '0; eos = '0; tx_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec++;
    check("reset tx_valid",  32'(tx_valid),  32'd0);
    check("reset tx_bit",    32'(tx_bit),    32'd0);
    check("reset tx_index",  32'(tx_index),  32'd0);
    check("reset busy",      32'(busy),      32'd0);
    check("reset send_done", 32'(send_done), 32'd0);

    // Full message from index 0, then eos=5, then single-bit eos=7.
    add_run(8'b1010_0110, 3'd0, 8'b1010_0110, 1'b0);
    add_run(8'b1010_0110, 3'd5, 8'b1010_0110, 1'b1);
    add_run(8'b1010_0110, 3'd7, 8'b1010_0110, 1'b1);
    // Reset from DONE, then a run where start, in_string and eos change mid-message.
    vecs.push_back(mk(1, 0, 8'h00, 3'd0, 1, 0, 0, 4'd0, 0, 1));
    base = vecs.size();
    add_run(8'b1010_0110, 3'd0, 8'b1010_0110, 1'b0);
    tmp = vecs[base + 10];
    tmp.start = 1'b1;
    tmp.eos   = 3'd6;
    vecs[base + 10] = tmp;
    for (int i = base + 10; i < vecs.size(); i++) begin
      tmp = vecs[i];
      tmp.data = 8'hFF;
      vecs[i] = tmp;
    end

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], $sformatf("row%0d", i));
    end

    // Stall at index 2 for five cycles, then accept.
    apply(mk(0, 1, 8'b1010_0110, 3'd2, 1, 0, 0, 4'd0, 0, 1), "stall start");
    for (int i = 0; i < 5; i++) begin
      apply(mk(0, 0, 8'b1010_0110, 3'd2, 0, 1, 1, 4'd2, 1, 0), $sformatf("stall hold%0d", i));
    end
    apply(mk(0, 0, 8'b1010_0110, 3'd2, 1, 1, 1, 4'd2, 1, 0), "stall accept");
    apply(mk(0, 0, 8'b1010_0110, 3'd2, 1, 0, 0, 4'd0, 1, 0), "stall gap0");
    apply(mk(0, 0, 8'b1010_0110, 3'd2, 1, 0, 0, 4'd0, 1, 0), "stall gap1");
    apply(mk(0, 0, 8'b1010_0110, 3'd2, 1, 1, 0, 4'd3, 1, 0), "stall idx3");
    apply(mk(0, 0, 8'b1010_0110, 3'd2, 1, 0, 0, 4'd0, 1, 0), "stall gap2");
    apply(mk(0, 0, 8'b1010_0110, 3'd2, 1, 0, 0, 4'd0, 1, 0), "stall gap3");

    // Reset at index 4 beats a same-cycle start and accept.
    apply(mk(1, 1, 8'b1010_0110, 3'd2, 1, 1, 0, 4'd4, 1, 0), "rst at idx4");
    n_vec++;
    check("post-rst tx_bit",   32'(tx_bit),   32'd0);
    check("post-rst tx_index", 32'(tx_index), 32'd0);
    apply(mk(0, 1, 8'h5A, 3'd1, 1, 0, 0, 4'd0, 0, 0), "restart");
    apply(mk(0, 0, 8'h5A, 3'd1, 1, 1, 1, 4'd1, 1, 0), "restart idx1");
    apply(mk(0, 0, 8'h5A, 3'd1, 1, 0, 0, 4'd0, 1, 0), "restart gap");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
